// File: rtl/tlu_trigger_tagger_if.sv
// Output stream bundle carrying two 32-bit words per trigger event
// (header, then timestamp) from the tagger to the readout packer.
interface tlu_trigger_tagger_if;
  // Handshake: a word moves on any clock edge where DOUT_VALID && DOUT_READY.
  // While DOUT_VALID && !DOUT_READY the master holds DOUT/DOUT_LAST stable, and
  // it never drops DOUT_VALID without a transfer (reset excepted). DOUT_READY
  // may toggle freely.
  logic [31:0] DOUT;
  logic        DOUT_VALID;
  logic        DOUT_READY;
  logic        DOUT_LAST;

  modport master (
    output DOUT,
    output DOUT_VALID,
    output DOUT_LAST,
    input  DOUT_READY
  );

  modport slave (
    input  DOUT,
    input  DOUT_VALID,
    input  DOUT_LAST,
    output DOUT_READY
  );
endinterface

// File: rtl/tlu_trigger_tagger.sv
// Timestamps decoded TLU trigger numbers, buffers them in a FIFO and streams each
// event as a header word plus a timestamp word; counts trigger gaps and overflow drops.
module tlu_trigger_tagger #(
  parameter int          FIFO_AW    = 4,
  parameter logic [7:0]  HEADER_TAG = 8'hA5
) (
  input  logic                 CLK,
  input  logic                 RST_SYS,
  input  logic                 ENABLE,
  input  logic                 TRIGGER_CNT_VALID,
  input  logic [15:0]          TRIGGER_CNT,
  tlu_trigger_tagger_if.master dout_if,
  output logic [FIFO_AW:0]     FIFO_LEVEL,
  output logic [15:0]          DROP_CNT,
  output logic [15:0]          GAP_CNT,
  output logic [1:0]           STATE_DBG
);

  localparam int               DEPTH   = 1 << FIFO_AW;
  localparam int               EW      = 50;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_TS   = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [31:0]        ts;
  logic [EW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full, empty;
  logic               capture, gap, wr_en, drop, pop;
  logic               first_seen, pend_ovf;
  logic [15:0]        last_cnt, cnt_exp;
  logic [EW-1:0]      wr_entry, rd_entry;

  logic               load_hdr, load_ts, clear_out;
  logic [31:0]        dout_r, ts_hold;
  logic               valid_r, last_r;

  // ------------------------------------------------------------------
  // Free-running timestamp, independent of ENABLE
  // ------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST_SYS) ts <= '0;
    else         ts <= ts + 32'd1;
  end

  // ------------------------------------------------------------------
  // Capture side: gap detection and FIFO write / drop decision
  // ------------------------------------------------------------------
  assign full     = (count == DEPTH_L);
  assign empty    = (count == '0);
  assign capture  = TRIGGER_CNT_VALID && ENABLE;
  assign cnt_exp  = last_cnt + 16'd1;  // 16'hFFFF -> 16'h0000 wraps naturally
  assign gap      = first_seen && (TRIGGER_CNT != cnt_exp);
  assign wr_en    = capture && !full;
  assign drop     = capture && full;
  assign wr_entry = {pend_ovf, gap, TRIGGER_CNT, ts};
  assign rd_entry = mem[rd_ptr];

  // Dropped events still advance the sequence tracker, so a drop alone is not a gap.
  always_ff @(posedge CLK) begin
    if (RST_SYS) begin
      first_seen <= 1'b0;
      last_cnt   <= '0;
      pend_ovf   <= 1'b0;
      DROP_CNT   <= '0;
      GAP_CNT    <= '0;
    end else if (capture) begin
      first_seen <= 1'b1;
      last_cnt   <= TRIGGER_CNT;
      if (drop) begin
        pend_ovf <= 1'b1;
        if (DROP_CNT != 16'hFFFF) DROP_CNT <= DROP_CNT + 16'd1;
      end else begin
        pend_ovf <= 1'b0;
      end
      if (gap && (GAP_CNT != 16'hFFFF)) GAP_CNT <= GAP_CNT + 16'd1;
    end
  end

  // ------------------------------------------------------------------
  // Event FIFO
  // ------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge CLK) begin
    if (RST_SYS) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign FIFO_LEVEL = count;

  // ------------------------------------------------------------------
  // Output FSM
  // ------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST_SYS) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    pop       = 1'b0;
    load_hdr  = 1'b0;
    load_ts   = 1'b0;
    clear_out = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          load_hdr = 1'b1;
          state_nx = S_HDR;
        end
      end
      S_HDR: begin
        if (dout_if.DOUT_READY) begin
          load_ts  = 1'b1;
          state_nx = S_TS;
        end
      end
      S_TS: begin
        if (dout_if.DOUT_READY) begin
          if (!empty) begin
            pop      = 1'b1;
            load_hdr = 1'b1;
            state_nx = S_HDR;
          end else begin
            clear_out = 1'b1;
            state_nx  = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Output registers only change on a load, so words stay put while stalled.
  always_ff @(posedge CLK) begin
    if (RST_SYS) begin
      dout_r  <= '0;
      ts_hold <= '0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end else if (load_hdr) begin
      dout_r  <= {HEADER_TAG, 4'h0, rd_entry[49], rd_entry[48], 2'b00, rd_entry[47:32]};
      ts_hold <= rd_entry[31:0];
      valid_r <= 1'b1;
      last_r  <= 1'b0;
    end else if (load_ts) begin
      dout_r  <= ts_hold;
      last_r  <= 1'b1;
    end else if (clear_out) begin
      dout_r  <= '0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end
  end

  assign dout_if.DOUT       = dout_r;
  assign dout_if.DOUT_VALID = valid_r;
  assign dout_if.DOUT_LAST  = last_r;
  assign STATE_DBG          = state;

  // ------------------------------------------------------------------
  // Internal sanity properties
  // ------------------------------------------------------------------
  a_no_pop_empty: assert property (@(posedge CLK) disable iff (RST_SYS) pop |-> !empty);
  a_level_range:  assert property (@(posedge CLK) disable iff (RST_SYS) count <= DEPTH_L);

endmodule

// File: tb/tb_tlu_trigger_tagger.sv
// Directed bench for tlu_trigger_tagger: stimulus pushes expected stream words into a
// queue, a negedge monitor pops and compares them and checks stall stability.
module tb_tlu_trigger_tagger;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        tvalid = 1'b0;
  logic [15:0] tcnt = '0;
  logic [4:0]  fifo_level;
  logic [15:0] drop_cnt, gap_cnt;
  logic [1:0]  state_dbg;
  logic [31:0] tb_ts = '0;
  int          ready_mode = 0;  // 0: stall, 1: always ready, 2: random

  always #5 clk = ~clk;

  tlu_trigger_tagger_if dif ();

  tlu_trigger_tagger #(.FIFO_AW(4), .HEADER_TAG(8'hA5)) dut (
    .CLK               (clk),
    .RST_SYS           (rst),
    .ENABLE            (enable),
    .TRIGGER_CNT_VALID (tvalid),
    .TRIGGER_CNT       (tcnt),
    .dout_if           (dif),
    .FIFO_LEVEL        (fifo_level),
    .DROP_CNT          (drop_cnt),
    .GAP_CNT           (gap_cnt),
    .STATE_DBG         (state_dbg)
  );

  // Reference cycle counter: the value it holds during a cycle is that cycle's timestamp.
  always @(posedge clk) tb_ts <= rst ? 32'd0 : tb_ts + 32'd1;

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       dif.DOUT_READY = 1'b0;
      1:       dif.DOUT_READY = 1'b1;
      default: dif.DOUT_READY = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];  // {last, data}
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic        stalled = 1'b0;
  logic [32:0] held;
  logic [32:0] e;

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        check("stall_hold", {31'd0, dif.DOUT_VALID, dif.DOUT_LAST, dif.DOUT}, {31'd0, 1'b1, held});
      if (dif.DOUT_VALID && dif.DOUT_READY) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %h expected none", {dif.DOUT_LAST, dif.DOUT});
        end else begin
          e = exp_q.pop_front();
          check("stream_word", {31'd0, dif.DOUT_LAST, dif.DOUT}, {31'd0, e});
        end
        stalled = 1'b0;
      end else if (dif.DOUT_VALID) begin
        stalled = 1'b1;
        held    = {dif.DOUT_LAST, dif.DOUT};
      end else begin
        stalled = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    tvalid     = 1'b0;
    ready_mode = 0;
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic pulse(input logic [15:0] cnt, input logic [31:0] hdr, input bit stored);
    tvalid = 1'b1;
    tcnt   = cnt;
    if (stored) begin
      exp_q.push_back({1'b0, hdr});
      exp_q.push_back({1'b1, tb_ts});
    end
    step();
    tvalid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || dif.DOUT_VALID) && k < 400) begin
      step();
      k++;
    end
    check(name, 64'(k < 400), 64'd1);
  endtask

  initial begin
    dif.DOUT_READY = 1'b0;
    step();

    // ---- T1: reset state, latency and first event ----
    do_reset();
    enable = 1'b1;
    check("rst_valid", 64'(dif.DOUT_VALID), 64'd0);
    check("rst_dout",  64'(dif.DOUT),       64'd0);
    check("rst_last",  64'(dif.DOUT_LAST),  64'd0);
    check("rst_level", 64'(fifo_level),     64'd0);
    check("rst_drop",  64'(drop_cnt),       64'd0);
    check("rst_gap",   64'(gap_cnt),        64'd0);
    ready_mode = 1;
    for (int i = 0; i < 200 && tb_ts != 32'd100; i++) step();
    tvalid = 1'b1;
    tcnt   = 16'h0005;
    exp_q.push_back({1'b0, 32'hA500_0005});
    exp_q.push_back({1'b1, 32'd100});
    step();
    tvalid = 1'b0;
    check("t1_valid_cycle1", 64'(dif.DOUT_VALID), 64'd0);
    step();
    check("t1_valid_cycle2", 64'(dif.DOUT_VALID), 64'd1);
    check("t1_hdr_cycle2",   64'(dif.DOUT),       64'hA500_0005);
    wait_drain("t1_drain");

    // ---- T2: gap detection, including the FFFF -> 0000 wrap ----
    do_reset();
    ready_mode = 1;
    pulse(16'h0007, 32'hA500_0007, 1);
    pulse(16'h0008, 32'hA500_0008, 1);
    pulse(16'h000A, 32'hA504_000A, 1);
    wait_drain("t2_drain_a");
    check("t2_gap_cnt_1", 64'(gap_cnt), 64'd1);
    pulse(16'hFFFF, 32'hA504_FFFF, 1);  // 10 -> FFFF is itself a gap
    pulse(16'h0000, 32'hA500_0000, 1);  // FFFF -> 0000 is not
    wait_drain("t2_drain_b");
    check("t2_gap_cnt_2", 64'(gap_cnt), 64'd2);

    // ---- T3: overflow. Event 0 moves into the output stage, so 19 pulses
    // leave 16 stored (events 1..16) and drop events 17 and 18. ----
    do_reset();
    for (int i = 0; i < 19; i++)
      pulse(16'(i), {16'hA500, 16'(i)}, i <= 16);
    check("t3_level_full", 64'(fifo_level), 64'd16);
    check("t3_drop_cnt",   64'(drop_cnt),   64'd2);
    check("t3_gap_cnt",    64'(gap_cnt),    64'd0);
    ready_mode = 1;
    wait_drain("t3_drain");
    check("t3_level_empty", 64'(fifo_level), 64'd0);
    pulse(16'd19, 32'hA508_0013, 1);  // ovf flag, no gap
    wait_drain("t3_drain_ovf");
    check("t3_drop_hold", 64'(drop_cnt), 64'd2);

    // ---- T4: random READY during a 3-event burst ----
    ready_mode = 2;
    pulse(16'd20, 32'hA500_0014, 1);
    pulse(16'd21, 32'hA500_0015, 1);
    pulse(16'd22, 32'hA500_0016, 1);
    wait_drain("t4_drain");
    check("t4_gap_cnt", 64'(gap_cnt), 64'd0);
    ready_mode = 1;

    // ---- T5: reset while header word is stalled ----
    do_reset();
    pulse(16'h0040, 32'hA500_0040, 1);
    pulse(16'h0050, 32'hA504_0050, 1);
    step();
    step();
    check("t5_stalled_valid", 64'(dif.DOUT_VALID), 64'd1);
    check("t5_stalled_hdr",   64'(dif.DOUT),       64'hA500_0040);
    check("t5_level_pre",     64'(fifo_level),     64'd1);
    check("t5_gap_pre",       64'(gap_cnt),        64'd1);
    do_reset();
    check("t5_valid_post", 64'(dif.DOUT_VALID), 64'd0);
    check("t5_level_post", 64'(fifo_level),     64'd0);
    check("t5_gap_post",   64'(gap_cnt),        64'd0);
    check("t5_drop_post",  64'(drop_cnt),       64'd0);
    ready_mode = 1;
    pulse(16'h0077, 32'hA500_0077, 1);
    wait_drain("t5_drain");
    check("t5_gap_after", 64'(gap_cnt), 64'd0);

    // ---- T6: ENABLE=0 ignores pulses entirely ----
    do_reset();
    ready_mode = 1;
    enable = 1'b0;
    pulse(16'h0003, 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      check("t6_no_output", 64'(dif.DOUT_VALID), 64'd0);
      step();
    end
    check("t6_level", 64'(fifo_level), 64'd0);
    check("t6_gap",   64'(gap_cnt),    64'd0);
    check("t6_drop",  64'(drop_cnt),   64'd0);
    enable = 1'b1;
    pulse(16'h0009, 32'hA500_0009, 1);
    wait_drain("t6_drain");
    check("t6_gap_first", 64'(gap_cnt), 64'd0);

    step();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
